keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses, and keeps the two most recent key values for the two-digit seven-segment multiplexer directly downstream. Drives one active-low row at a time, samples the active-low column inputs through a synchronizer, and registers exactly one key event per physical press. Its `digitNew`/`digitOld` outputs connect straight to the display mux's `sw1`/`sw2` digit inputs.

## Interface
- `SCAN_CYCLES`, default 2400: cycles each row stays driven before its columns are sampled; must be ≥ 3.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-low; all state clears immediately while `reset`=0.
- `col` in 4: raw column lines, active-low (pulled up); asynchronous to `clk`.
- `row` out 4: row drive, one-hot active-low; all other rows held high.
- `digitNew` out 4: most recently accepted key value, feeds display digit 1.
- `digitOld` out 4: previously accepted key value, feeds display digit 2.
- `keyValid` out 1: one-cycle pulse on the cycle the digit outputs update.

## Operation
- `col` passes through a 2-flop synchronizer (`colS`); all decisions use `colS`.
- Key map, by row r and column c, as hex nibble:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- FSM states: SCAN, DEBOUNCE, ACCEPT, HELD, RELEASE.
- SCAN: drive row r low and count dwell cycles.
  - On dwell count `SCAN_CYCLES-1`, sample `colS`.
  - If all high: advance to r+1 (3 wraps to 0), reset the count, stay in SCAN.
  - If any low: latch r and the lowest-index low column c; go to DEBOUNCE.
- DEBOUNCE: hold row r; require `colS[c]`=0 for `DEBOUNCE_CYCLES` consecutive cycles, then go to ACCEPT.
  - Any cycle with `colS[c]`=1: return to SCAN on the same row r, with a fresh dwell count.
- ACCEPT (one cycle):
  - `digitOld`←`digitNew`, `digitNew`←map(r,c), `keyValid`=1.
  - Go to HELD.
- HELD: hold row r. Other keys pressed meanwhile are ignored; only column c is watched. When `colS[c]`=1, go to RELEASE.
- RELEASE: require `colS[c]`=1 for `DEBOUNCE_CYCLES` consecutive cycles, then go to SCAN at row r+1.
  - Any cycle with `colS[c]`=0: return to HELD, with no new event.
- Simultaneous keys in the same row: lowest column index wins.
- Reset value of every output: `row`=4'b1110, `digitNew`=0, `digitOld`=0, `keyValid`=0. FSM resets to SCAN at row 0 with counters and synchronizer cleared.
- Reset asserted mid-press: the FSM re-enters SCAN after reset. A key still held is then re-detected and re-debounced, producing one new event.

## Timing
- Counters are sized to hold `DEBOUNCE_CYCLES` and `SCAN_CYCLES` and are shared across states; every state transition reloads them to 0.
- Synchronizer latency: 2 cycles. The `SCAN_CYCLES` ≥ 3 rule guarantees the sample reflects the row being driven.
- Press latency: from `colS[c]` going low during row r's dwell, at most `SCAN_CYCLES` to the sample, plus `DEBOUNCE_CYCLES`, plus 1 cycle to ACCEPT.
- `digitNew`, `digitOld` and `keyValid` change on the same clock edge.
- `keyValid` is high for exactly 1 cycle per accepted press.
- `row` changes only on SCAN row advance and on the exit from RELEASE.
- `row` is registered, with no combinational path from `col`.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum;
  - the 16-entry key map as a constant 4-bit array indexed {r,c};
  - the row-drive one-hot constants.
- Sub-module `col_sync`: a 4-bit, 2-flop synchronizer with async active-low reset to 4'b1111.
- Everything else lives in the single `keypad_scanner` module.

## Test plan
Parameters: `SCAN_CYCLES`=4, `DEBOUNCE_CYCLES`=8. The bench keypad model sets `col[c]=0` iff key (r,c) is pressed and `row[r]=0`.
- Reset then idle 100 cycles:
  - `row` cycles 1110→1101→1011→0111→1110, each held 4 cycles;
  - `keyValid` never asserts;
  - digits stay 0.
- Press (1,1) cleanly for 40 cycles, then release:
  - one `keyValid` pulse;
  - `digitNew`=5, `digitOld`=0;
  - scanning resumes at row 2 after 8 stable-release cycles.
- Next, press (3,1), then (0,3):
  - after the first press, `digitNew`=0, `digitOld`=5;
  - after the second, `digitNew`=A, `digitOld`=0;
  - exactly two pulses.
- Bounce: press (2,2) toggling every 3 cycles for 30 cycles, then stable for 12 cycles:
  - exactly one pulse, `digitNew`=9;
  - the same bounce pattern on release produces no extra pulse.
- Hold (0,0), add (0,2) and (3,3) during HELD, then release all:
  - one pulse with value 1;
  - no event for the extra keys until all are released and re-scanned.
- Assert `reset` during DEBOUNCE of (2,0):
  - outputs return to their reset values asynchronously;
  - with the key still held after reset release, exactly one pulse, `digitNew`=7.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
//
// Purpose : FSM state encoding, key map, row-drive patterns and the
//           lowest-pressed-column helper used by keypad_scanner.
// Ports   : none (package).

package keypad_pkg;

   typedef enum logic [2:0] {
      ST_SCAN     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_ACCEPT   = 3'd2,
      ST_HELD     = 3'd3,
      ST_RELEASE  = 3'd4
   } state_t;

   // Key value indexed by {row, col}; element 0 is row 0 / column 0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,   // row 3, columns 3..0
      4'hC, 4'h9, 4'h8, 4'h7,   // row 2
      4'hB, 4'h6, 4'h5, 4'h4,   // row 1
      4'hA, 4'h3, 4'h2, 4'h1    // row 0
   };

   // One-hot active-low row drive, indexed by row number.
   localparam logic [3:0][3:0] ROW_DRIVE = {
      4'b0111, 4'b1011, 4'b1101, 4'b1110
   };

   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Index of the lowest active-low column; callers only use it when
   // at least one column is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] v);
      if (!v[0])      return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// rtl/keypad_scanner_col_sync.sv - 2-flop synchronizer for the column inputs
//
// Purpose : bring the asynchronous, active-low column lines into the clk
//           domain. Resets to all-high (no key pressed).
// Ports   : clk   - system clock
//           reset - asynchronous active-low reset
//           col   - raw column lines (async)
//           colS  - synchronized column lines

module col_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] colS
);

   logic [3:0] meta_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 4'b1111;
         colS   <= 4'b1111;
      end else begin
         meta_q <= col;
         colS   <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce and two-digit history
//
// Purpose : drives one row low at a time, detects a pressed key on the
//           synchronized columns, debounces press and release, and keeps the
//           two most recent key values for the downstream display mux.
// Ports   : clk      - system clock
//           reset    - asynchronous active-low reset
//           col      - raw active-low column lines (async to clk)
//           row      - registered one-hot active-low row drive
//           digitNew - most recently accepted key value
//           digitOld - previously accepted key value
//           keyValid - one-cycle pulse when the digit outputs update

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 2400,
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] digitNew,
   output logic [3:0] digitOld,
   output logic       keyValid
);

   // One counter serves both the row dwell and the debounce windows.
   localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       colS;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic             key_down;
   logic             accept_d;
   logic [3:0]       row_d;
   logic [3:0]       key_val;

   col_sync u_col_sync (
      .clk   (clk),
      .reset (reset),
      .col   (col),
      .colS  (colS)
   );

   // Only the latched column matters once a key has been found.
   assign key_down = ~colS[col_idx_q];

   // State register plus the datapath registers that move with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_SCAN;
         cnt_q     <= '0;
         row_idx_q <= 2'd0;
         col_idx_q <= 2'd0;
         row       <= ROW_RESET;
         digitNew  <= 4'h0;
         digitOld  <= 4'h0;
         keyValid  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_idx_q <= row_idx_d;
         col_idx_q <= col_idx_d;
         row       <= row_d;
         keyValid  <= accept_d;
         // Digits load on the same edge that raises keyValid.
         if (accept_d) begin
            digitOld <= digitNew;
            digitNew <= key_val;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      row_idx_d = row_idx_q;
      col_idx_d = col_idx_q;
      case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (&colS) begin
                  row_idx_d = row_idx_q + 2'd1;
               end else begin
                  col_idx_d = lowest_low(colS);
                  state_d   = ST_DEBOUNCE;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (!key_down) begin
               // Bounce: re-dwell on the same row before sampling again.
               state_d = ST_SCAN;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_ACCEPT;
               cnt_d   = '0;
            end
         end
         ST_ACCEPT: begin
            state_d = ST_HELD;
            cnt_d   = '0;
         end
         ST_HELD: begin
            cnt_d = '0;
            if (!key_down) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (key_down) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = ST_SCAN;
               cnt_d     = '0;
               row_idx_d = row_idx_q + 2'd1;
            end
         end
         default: begin
            state_d = ST_SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode: values loaded into the output registers on the next edge.
   always_comb begin
      accept_d = (state_d == ST_ACCEPT);
      key_val  = KEY_MAP[{row_idx_q, col_idx_q}];
      row_d    = ROW_DRIVE[row_idx_d];
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner

module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] digitNew;
   logic [3:0] digitOld;
   logic       keyValid;

   logic [3:0] pressed [4];
   logic [7:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   logic kv_prev = 1'b0;

   keypad_scanner #(
      .SCAN_CYCLES     (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .col      (col),
      .row      (row),
      .digitNew (digitNew),
      .digitOld (digitOld),
      .keyValid (keyValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a column is pulled low by any pressed key on a driven row.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (row[r] == 1'b0) col = col & ~pressed[r];
      end
   end

   // Monitor: every keyValid pulse pops one expected {digitNew,digitOld}.
   always @(negedge clk) begin
      if (reset) begin
         if (keyValid) begin
            logic [7:0] e;
            pulses++;
            checks++;
            if (kv_prev) begin
               errors++;
               $display("FAIL keyvalid_width: keyValid high on consecutive cycles, required 1-cycle pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: got new=%h old=%h, required no pulse", digitNew, digitOld);
            end else begin
               e = exp_q.pop_front();
               if ({digitNew, digitOld} !== e) begin
                  errors++;
                  $display("FAIL digits: got new=%h old=%h, required new=%h old=%h",
                           digitNew, digitOld, e[7:4], e[3:0]);
               end
            end
         end
         kv_prev = keyValid;
      end else begin
         kv_prev = 1'b0;
      end
   end

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic wait_pulses(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (pulses < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check_int(name, pulses, target);
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
   endtask

   initial begin : stim
      logic [3:0] rows_exp [4];
      int n;
      rows_exp[0] = 4'b1110; rows_exp[1] = 4'b1101;
      rows_exp[2] = 4'b1011; rows_exp[3] = 4'b0111;
      release_all();
      reset = 1'b0;
      repeat (3) @(negedge clk);

      check4("reset_row", row, 4'b1110);
      check4("reset_new", digitNew, 4'h0);
      check4("reset_old", digitOld, 4'h0);
      check4("reset_kv", {3'b000, keyValid}, 4'h0);

      // Idle scan: each row held for 4 cycles, then wrap.
      reset = 1'b1;
      check4("scan_row_0", row, rows_exp[0]);
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         check4($sformatf("scan_row_%0d", k), row, rows_exp[(k / 4) % 4]);
      end
      repeat (80) @(negedge clk);
      check_int("idle_pulses", pulses, 0);
      check4("idle_new", digitNew, 4'h0);

      // Clean press of (1,1) -> 5, then release and resume at row 2.
      exp_q.push_back({4'h5, 4'h0});
      pressed[1][1] = 1'b1;
      wait_pulses("press_11", 1, 100);
      repeat (20) @(negedge clk);
      pressed[1][1] = 1'b0;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (row != 4'b1101) break;
      end
      check_int("release_latency", n, 11);
      check4("resume_row2", row, 4'b1011);

      // (3,1) -> 0, then (0,3) -> A.
      repeat (10) @(negedge clk);
      exp_q.push_back({4'h0, 4'h5});
      pressed[3][1] = 1'b1;
      wait_pulses("press_31", 2, 100);
      repeat (10) @(negedge clk);
      pressed[3][1] = 1'b0;
      repeat (30) @(negedge clk);
      exp_q.push_back({4'hA, 4'h0});
      pressed[0][3] = 1'b1;
      wait_pulses("press_03", 3, 100);
      repeat (10) @(negedge clk);
      pressed[0][3] = 1'b0;
      repeat (30) @(negedge clk);
      check_int("two_pulses", pulses, 3);

      // Bouncy press and bouncy release of (2,2) -> 9, one event only.
      exp_q.push_back({4'h9, 4'hA});
      for (int i = 0; i < 10; i++) begin
         pressed[2][2] = (i % 2 == 0);
         repeat (3) @(negedge clk);
      end
      pressed[2][2] = 1'b1;
      wait_pulses("bounce_press", 4, 60);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         pressed[2][2] = (i % 2 == 1);
         repeat (3) @(negedge clk);
      end
      pressed[2][2] = 1'b0;
      repeat (40) @(negedge clk);
      check_int("bounce_release", pulses, 4);

      // Hold (0,0); extra keys while held raise no event.
      exp_q.push_back({4'h1, 4'h9});
      pressed[0][0] = 1'b1;
      wait_pulses("hold_00", 5, 100);
      repeat (5) @(negedge clk);
      pressed[0][2] = 1'b1;
      pressed[3][3] = 1'b1;
      repeat (30) @(negedge clk);
      release_all();
      repeat (60) @(negedge clk);
      check_int("extra_keys_ignored", pulses, 5);

      // Reset during debounce of (2,0); key held through reset.
      n = 0;
      while (row != 4'b1011 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check4("find_row2", row, 4'b1011);
      pressed[2][0] = 1'b1;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      #1;
      check4("async_row", row, 4'b1110);
      check4("async_new", digitNew, 4'h0);
      check4("async_old", digitOld, 4'h0);
      check4("async_kv", {3'b000, keyValid}, 4'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      exp_q.push_back({4'h7, 4'h0});
      wait_pulses("post_reset_press", 6, 100);
      repeat (10) @(negedge clk);
      release_all();
      repeat (40) @(negedge clk);
      check_int("final_pulses", pulses, 6);
      check_int("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
